// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 32-bit MIPS pipeline: program counter, IF/ID register,
// stall handling, EX branch / ID jump redirects with bubble insertion, retired-fetch counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] IMEM_DATA,
    input  logic        STALL,
    input  logic        EX_BRANCH_TAKEN,
    input  logic [31:0] EX_BRANCH_TARGET,
    input  logic        ID_JUMP,
    input  logic [25:0] ID_JADDR,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] IF_ID_INSTR,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_VALID,
    output logic [31:0] FETCH_COUNT
);

    // The PC is kept word-aligned even if an unaligned reset vector is configured.
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        ACT_FETCH  = 2'd0,
        ACT_BRANCH = 2'd1,
        ACT_JUMP   = 2'd2,
        ACT_STALL  = 2'd3
    } act_t;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic [31:0] r_count;

    act_t        w_act;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc4_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_count_nxt;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Select the action for this edge; a jump in ID only counts when ID holds a real instruction.
    always_comb begin
        w_act = ACT_FETCH;
        if (EX_BRANCH_TAKEN) begin
            w_act = ACT_BRANCH;
        end else if (ID_JUMP && r_valid) begin
            w_act = ACT_JUMP;
        end else if (STALL) begin
            w_act = ACT_STALL;
        end else begin
            w_act = ACT_FETCH;
        end
    end

    // Next-state values for PC, IF/ID and the fetch counter.
    always_comb begin
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;
        w_count_nxt = r_count;
        case (w_act)
            ACT_BRANCH: begin
                w_pc_nxt    = {EX_BRANCH_TARGET[31:2], 2'b00};
                w_instr_nxt = NOP_WORD;
                w_pc4_nxt   = 32'h0000_0000;
                w_valid_nxt = 1'b0;
            end
            ACT_JUMP: begin
                // Jump region comes from PC+4 of the jump itself, which sits in IF/ID.
                w_pc_nxt    = {r_pc4[31:28], ID_JADDR, 2'b00};
                w_instr_nxt = NOP_WORD;
                w_pc4_nxt   = 32'h0000_0000;
                w_valid_nxt = 1'b0;
            end
            ACT_STALL: begin
                w_pc_nxt    = r_pc;
                w_instr_nxt = r_instr;
                w_pc4_nxt   = r_pc4;
                w_valid_nxt = r_valid;
                w_count_nxt = r_count;
            end
            ACT_FETCH: begin
                w_pc_nxt    = w_pc_plus4;
                w_instr_nxt = IMEM_DATA;
                w_pc4_nxt   = w_pc_plus4;
                w_valid_nxt = 1'b1;
                w_count_nxt = r_count + 32'd1;
            end
            default: begin
                w_pc_nxt    = RESET_PC_AL;
                w_instr_nxt = NOP_WORD;
                w_pc4_nxt   = 32'h0000_0000;
                w_valid_nxt = 1'b0;
                w_count_nxt = 32'h0000_0000;
            end
        endcase
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_pc    <= RESET_PC_AL;
            r_instr <= NOP_WORD;
            r_pc4   <= 32'h0000_0000;
            r_valid <= 1'b0;
            r_count <= 32'h0000_0000;
        end else begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pc4   <= w_pc4_nxt;
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign IMEM_ADDR   = r_pc;
    assign IF_ID_INSTR = r_instr;
    assign IF_ID_PC4   = r_pc4;
    assign IF_ID_VALID = r_valid;
    assign FETCH_COUNT = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a rule-level reference model pushes the expected
// post-edge state for every edge; a negedge monitor pops and compares against the DUT.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic [31:0] imem_data;
    logic        stall;
    logic        ex_br;
    logic [31:0] ex_tgt;
    logic        id_jump;
    logic [25:0] id_jaddr;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
        .CLOCK(clock), .RESET(reset), .IMEM_DATA(imem_data), .STALL(stall),
        .EX_BRANCH_TAKEN(ex_br), .EX_BRANCH_TARGET(ex_tgt),
        .ID_JUMP(id_jump), .ID_JADDR(id_jaddr),
        .IMEM_ADDR(imem_addr), .IF_ID_INSTR(if_id_instr), .IF_ID_PC4(if_id_pc4),
        .IF_ID_VALID(if_id_valid), .FETCH_COUNT(fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'h2008_0001 + (a >> 2);
    endfunction

    assign imem_data = imem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // One clock edge: drive inputs, let the edge happen, apply the rules to the model.
    task automatic cyc(input logic rst, input logic stl, input logic br,
                       input logic [31:0] tgt, input logic jmp, input logic [25:0] ja);
        @(negedge clock);
        reset = rst; stall = stl; ex_br = br; ex_tgt = tgt; id_jump = jmp; id_jaddr = ja;
        @(posedge clock);
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;
        end else if (br) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (jmp && m_valid) begin
            m_pc = {m_pc4[31:28], ja, 2'b00};
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!stl) begin
            m_instr = imem_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
        end
        exp_q.push_back('{addr: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, count: m_count});
    endtask

    task automatic norm();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    endtask

    // Monitor: every cycle after an edge the DUT presents a new state; compare it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr",   imem_addr,   e.addr);
                chk("if_id_instr", if_id_instr, e.instr);
                chk("if_id_pc4",   if_id_pc4,   e.pc4);
                chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
                chk("fetch_count", fetch_count, e.count);
            end
        end
    end

    initial begin
        logic [31:0] rnd;
        int r;
        reset = 1'b1; stall = 1'b0; ex_br = 1'b0; ex_tgt = 32'h0; id_jump = 1'b0; id_jaddr = 26'h0;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 32'h0;

        // reset, then 4 free-running edges
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        #1 chk("reset_addr", imem_addr, 32'h0);
        chk("reset_valid", {31'h0, if_id_valid}, 32'h0);
        norm(); #1 chk("valid_first_edge", {31'h0, if_id_valid}, 32'h1);
        norm(); #1 chk("addr_after2", imem_addr, 32'h8);
        // stall three edges at PC=0x8
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
        #1 chk("stall_addr", imem_addr, 32'h8);
        chk("stall_count", fetch_count, 32'd2);
        norm(); #1 chk("unstall_addr", imem_addr, 32'hC);
        norm(); #1 chk("addr_after4", imem_addr, 32'h10);
        chk("pc4_after4", if_id_pc4, 32'h10);
        chk("count_after4", fetch_count, 32'd4);

        // EX branch together with STALL
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0043, 1'b0, 26'h0);
        #1 chk("br_addr", imem_addr, 32'h40);
        chk("br_count", fetch_count, 32'd4);
        norm(); #1 chk("br_target_word", if_id_instr, 32'h2008_0011);

        // ID jump from 0x8000000C's successor, then same inputs with a bubble in ID
        cyc(1'b0, 1'b0, 1'b1, 32'h8000_000C, 1'b0, 26'h0);
        norm();
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 26'h000_0100);
        #1 chk("jump_addr", imem_addr, 32'h8000_0400);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h000_0100);
        #1 chk("jump_ignored", imem_addr, 32'h8000_0404);

        // EX branch and ID jump together: EX wins
        norm();
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 26'h3FF_FFFF);
        #1 chk("ex_wins", imem_addr, 32'h200);

        // reset mid-stream at PC=0x1C, count=7
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        repeat (7) norm();
        #1 chk("pre_reset_count", fetch_count, 32'd7);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        #1 chk("mid_reset_count", fetch_count, 32'd0);

        // PC wrap from 0xFFFFFFFC
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
        norm(); #1 chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            rnd = $urandom();
            cyc((r < 3) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                (r >= 3 && r < 15) ? 1'b1 : 1'b0,
                $urandom(),
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                rnd[25:0]);
        end

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
        @(posedge clock);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
